// File: rtl/logic_gates_bist.sv
// logic_gates_bist
// Self-test engine for a two-input basic-gate block. It walks the shared
// a/b stimulus through 00, 01, 10, 11 and waits SETTLE_CYCLES after each
// vector. It then compares the seven gate responses against locally
// computed expectations and accumulates sticky per-gate and per-vector
// failure flags plus a mismatch count.
//
// Handshake: start is a level request that is sampled only in IDLE. A run
// is accepted on the edge where start is high in IDLE. busy stays high
// until the last CHECK. done pulses for one cycle, and the results (pass,
// fail_mask, fail_vec, err_count) hold until the next accepted start.
module logic_gates_bist #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       drv_a,
   output logic       drv_b,
   input  logic [6:0] gate_in,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] fail_mask,
   output logic [3:0] fail_vec,
   output logic [4:0] err_count,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_APPLY  = 3'd1,
      S_SETTLE = 3'd2,
      S_CHECK  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

   state_t     state_q, state_d;
   logic [1:0] vec_q, vec_d;
   logic [3:0] cnt_q, cnt_d;
   logic       drv_a_q, drv_a_d;
   logic       drv_b_q, drv_b_d;
   logic       pass_q, pass_d;
   logic [6:0] fail_mask_q, fail_mask_d;
   logic [3:0] fail_vec_q, fail_vec_d;
   logic [4:0] err_count_q, err_count_d;

   logic [6:0] expected;
   logic [6:0] mism;
   logic [2:0] mism_cnt;

   function automatic logic [2:0] popcount7(input logic [6:0] x);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 7; i++) begin
         n = n + {2'b00, x[i]};
      end
      return n;
   endfunction

   // State register and all datapath registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         vec_q       <= '0;
         cnt_q       <= '0;
         drv_a_q     <= 1'b0;
         drv_b_q     <= 1'b0;
         pass_q      <= 1'b0;
         fail_mask_q <= '0;
         fail_vec_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         vec_q       <= vec_d;
         cnt_q       <= cnt_d;
         drv_a_q     <= drv_a_d;
         drv_b_q     <= drv_b_d;
         pass_q      <= pass_d;
         fail_mask_q <= fail_mask_d;
         fail_vec_q  <= fail_vec_d;
         err_count_q <= err_count_d;
      end
   end

   // Next-state logic: one pass over four vectors, then back to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_APPLY;
         S_APPLY:  state_d = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
         S_SETTLE: if (cnt_q <= 4'd1) state_d = S_CHECK;
         S_CHECK:  state_d = (vec_q == 2'd3) ? S_DONE : S_APPLY;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Response comparison against the ideal gate set for the driven vector.
   always_comb begin
      expected = {~(drv_a_q ^ drv_b_q), drv_a_q ^ drv_b_q, ~(drv_a_q | drv_b_q),
                  ~(drv_a_q & drv_b_q), ~drv_a_q, drv_a_q | drv_b_q, drv_a_q & drv_b_q};
      mism     = gate_in ^ expected;
      mism_cnt = popcount7(mism);
   end

   // Datapath next values. The stimulus is loaded on the edge that enters
   // APPLY, so it is already stable for the whole APPLY..CHECK window.
   always_comb begin
      vec_d       = vec_q;
      cnt_d       = cnt_q;
      drv_a_d     = drv_a_q;
      drv_b_d     = drv_b_q;
      pass_d      = pass_q;
      fail_mask_d = fail_mask_q;
      fail_vec_d  = fail_vec_q;
      err_count_d = err_count_q;
      case (state_q)
         S_IDLE: begin
            drv_a_d = 1'b0;
            drv_b_d = 1'b0;
            if (start) begin
               vec_d       = '0;
               pass_d      = 1'b0;
               fail_mask_d = '0;
               fail_vec_d  = '0;
               err_count_d = '0;
            end
         end
         S_APPLY: begin
            cnt_d = SETTLE_INIT;
         end
         S_SETTLE: begin
            cnt_d = cnt_q - 4'd1;
         end
         S_CHECK: begin
            fail_mask_d = fail_mask_q | mism;
            fail_vec_d  = fail_vec_q | (4'(|mism) << vec_q);
            err_count_d = err_count_q + {2'b00, mism_cnt};
            if (vec_q == 2'd3) begin
               // Verdict becomes visible together with done.
               pass_d  = ((fail_mask_q | mism) == 7'd0);
               drv_a_d = 1'b0;
               drv_b_d = 1'b0;
            end else begin
               vec_d   = vec_q + 2'd1;
               drv_a_d = vec_d[1];
               drv_b_d = vec_d[0];
            end
         end
         S_DONE: begin
            drv_a_d = 1'b0;
            drv_b_d = 1'b0;
         end
         default: begin
            drv_a_d = 1'b0;
            drv_b_d = 1'b0;
         end
      endcase
   end

   // Output decode from the current state and result registers.
   always_comb begin
      busy      = (state_q == S_APPLY) || (state_q == S_SETTLE) || (state_q == S_CHECK);
      done      = (state_q == S_DONE);
      drv_a     = drv_a_q;
      drv_b     = drv_b_q;
      pass      = pass_q;
      fail_mask = fail_mask_q;
      fail_vec  = fail_vec_q;
      err_count = err_count_q;
      dbg_state = state_q;
   end

endmodule

// File: tb/tb_logic_gates_bist.sv
// Bench for logic_gates_bist: a behavioural gate block with injectable
// faults feeds two DUTs (settle 2 and settle 0). Each run is checked cycle
// by cycle for stimulus/busy/done timing and at the end for the results.
module tb_logic_gates_bist;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   sel;
  int   fault_mode;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic       start2, drv_a2, drv_b2, busy2, done2, pass2;
  logic [6:0] gin2, fm2;
  logic [3:0] fv2;
  logic [4:0] ec2;
  logic [2:0] st2;
  logic       start0, drv_a0, drv_b0, busy0, done0, pass0;
  logic [6:0] gin0, fm0;
  logic [3:0] fv0;
  logic [4:0] ec0;
  logic [2:0] st0;

  assign start2 = start & (sel == 0);
  assign start0 = start & (sel == 1);

  logic_gates_bist #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .drv_a(drv_a2), .drv_b(drv_b2),
    .gate_in(gin2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(fm2), .fail_vec(fv2), .err_count(ec2), .dbg_state(st2));

  logic_gates_bist #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .drv_a(drv_a0), .drv_b(drv_b0),
    .gate_in(gin0), .busy(busy0), .done(done0), .pass(pass0),
    .fail_mask(fm0), .fail_vec(fv0), .err_count(ec0), .dbg_state(st0));

  // Gate block model with fault injection.
  function automatic logic [6:0] gate_model(input logic a, input logic b, input int f);
    logic [6:0] g;
    g = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
    case (f)
      1: g[5] = 1'b0;          // xor stuck at 0
      2: g[2] = a;             // not output inverted
      3: g[0] = 1'b1;          // and stuck at 1
      4: if (a & b) g = ~g;    // every output wrong on vector 11
      default: ;
    endcase
    return g;
  endfunction

  always_comb gin2 = gate_model(drv_a2, drv_b2, fault_mode);
  always_comb gin0 = gate_model(drv_a0, drv_b0, fault_mode);

  // Outputs of the selected DUT.
  logic       o_drv_a, o_drv_b, o_busy, o_done, o_pass;
  logic [6:0] o_fm;
  logic [3:0] o_fv;
  logic [4:0] o_ec;
  assign o_drv_a = (sel == 1) ? drv_a0 : drv_a2;
  assign o_drv_b = (sel == 1) ? drv_b0 : drv_b2;
  assign o_busy  = (sel == 1) ? busy0  : busy2;
  assign o_done  = (sel == 1) ? done0  : done2;
  assign o_pass  = (sel == 1) ? pass0  : pass2;
  assign o_fm    = (sel == 1) ? fm0    : fm2;
  assign o_fv    = (sel == 1) ? fv0    : fv2;
  assign o_ec    = (sel == 1) ? ec0    : ec2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    int         fault;
    logic [6:0] exp_mask;
    logic [3:0] exp_vec;
    logic [4:0] exp_err;
    logic       exp_pass;
  } vec_t;

  // One full run with cycle-accurate timing checks; optional start spam
  // during cycles 3..(last+1) must be ignored.
  task automatic run_check(input int s, input int f, input bit spam, input logic [6:0] em,
                           input logic [3:0] ev, input logic [4:0] ec, input logic ep,
                           input string name);
    int         last;
    int         dones;
    logic [3:0] exp_sig;
    logic [1:0] v;
    last = 4 * (2 + s);
    sel = (s == 0) ? 1 : 0;
    fault_mode = f;
    dones = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= last + 2; c++) begin
      @(negedge clk);
      v = 2'((c - 1) / (2 + s));
      if (c <= last) exp_sig = {2'b10, v[1], v[0]};
      else if (c == last + 1) exp_sig = 4'b0100;
      else exp_sig = 4'b0000;
      check($sformatf("%s_c%0d_busy_done_a_b", name, c),
            {28'd0, o_busy, o_done, o_drv_a, o_drv_b}, {28'd0, exp_sig});
      if (o_done) dones++;
      if (c == last + 1) begin
        check($sformatf("%s_fail_mask", name), {25'd0, o_fm}, {25'd0, em});
        check($sformatf("%s_fail_vec", name), {28'd0, o_fv}, {28'd0, ev});
        check($sformatf("%s_err_count", name), {27'd0, o_ec}, {27'd0, ec});
      end
      if (c >= last + 1)
        check($sformatf("%s_c%0d_pass", name, c), {31'd0, o_pass}, {31'd0, ep});
      start = spam && (c >= 3) && (c <= last + 1);
    end
    start = 1'b0;
    check($sformatf("%s_done_pulses", name), dones, 1);
  endtask

  task automatic check_all_zero(input string name);
    check($sformatf("%s_dut2", name),
          {13'd0, drv_a2, drv_b2, busy2, done2, pass2, fm2, fv2, ec2},
          32'd0);
    check($sformatf("%s_dut0", name),
          {13'd0, drv_a0, drv_b0, busy0, done0, pass0, fm0, fv0, ec0},
          32'd0);
  endtask

  vec_t tbl[5];
  int   dcount;

  initial begin
    tbl[0] = '{"clean",     0, 7'b0000000, 4'b0000, 5'd0, 1'b1};
    tbl[1] = '{"xor_stuck", 1, 7'b0100000, 4'b0110, 5'd2, 1'b0};
    tbl[2] = '{"not_inv",   2, 7'b0000100, 4'b1111, 5'd4, 1'b0};
    tbl[3] = '{"reclean",   0, 7'b0000000, 4'b0000, 5'd0, 1'b1};
    tbl[4] = '{"and_hi",    3, 7'b0000001, 4'b0111, 5'd3, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    sel = 0;
    fault_mode = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table-driven runs at settle 2.
    for (int i = 0; i < 5; i++) begin
      run_check(2, tbl[i].fault, 1'b0, tbl[i].exp_mask, tbl[i].exp_vec,
                tbl[i].exp_err, tbl[i].exp_pass, tbl[i].name);
    end

    // All seven outputs wrong on the last vector only.
    run_check(2, 4, 1'b0, 7'b1111111, 4'b1000, 5'd7, 1'b0, "all_bad_v3");

    // start held high through the run must not restart or extend it.
    run_check(2, 0, 1'b1, 7'b0000000, 4'b0000, 5'd0, 1'b1, "spam");

    // Zero settle time.
    run_check(0, 0, 1'b0, 7'b0000000, 4'b0000, 5'd0, 1'b1, "s0_clean");
    run_check(0, 1, 1'b0, 7'b0100000, 4'b0110, 5'd2, 1'b0, "s0_xor");

    // Reset in the middle of cycle 6 of a faulty run.
    sel = 0;
    fault_mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun_err_before_rst", {27'd0, ec2}, 32'd1);
    check("midrun_busy_before_rst", {31'd0, busy2}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check_all_zero("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done2) dcount++;
    end
    check("midrun_no_done", dcount, 0);
    check_all_zero("midrun_after");
    run_check(2, 0, 1'b0, 7'b0000000, 4'b0000, 5'd0, 1'b1, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
